// File: rtl/pipe_ctrl.sv
// Hazard controller for the five-stage core: per-cycle stall/flush/bubble/redirect
// generation plus the IDLE/BUSY/DONE sequencer for multi-cycle EX units.
module pipe_ctrl #(
    parameter int MULTI_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id2ex_mem_read_i,
    input  logic             id2ex_rd_en_i,
    input  logic [4:0]       id2ex_rd_index_i,
    input  logic             if2id_rs1_en_i,
    input  logic             if2id_rs2_en_i,
    input  logic [4:0]       if2id_rs1_index_i,
    input  logic [4:0]       if2id_rs2_index_i,
    input  logic             ex_redirect_i,
    input  logic             ex_multi_i,
    input  logic             ex_multi_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_stall_o,
    output logic             if2id_stall_o,
    output logic             id2ex_stall_o,
    output logic             ex2mem_stall_o,
    output logic             if2id_flush_o,
    output logic             id2ex_flush_o,
    output logic             mem2wb_bubble_o,
    output logic             pc_redirect_o,
    output logic             multi_start_o,
    output logic             multi_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TMO_W = $clog2(MULTI_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MULTI_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MULTI_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             err_nxt;
    logic             start;
    logic             mem_stall;
    logic             multi_stall;
    logic             lu_hazard;
    logic             rs1_hit;
    logic             rs2_hit;

    always_comb begin
        mem_stall   = mem_req_i & ~mem_ready_i;
        multi_stall = ((state == IDLE) & ex_multi_i) | (state == BUSY);
        rs1_hit     = if2id_rs1_en_i & (if2id_rs1_index_i == id2ex_rd_index_i);
        rs2_hit     = if2id_rs2_en_i & (if2id_rs2_index_i == id2ex_rd_index_i);
        lu_hazard   = id2ex_mem_read_i & id2ex_rd_en_i & (id2ex_rd_index_i != 5'd0)
                    & (rs1_hit | rs2_hit);
    end

    // Sequencer: the start pulse is held off while memory is waiting, and the
    // timeout counter saturates so the error flag stays meaningful forever.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        err_nxt   = multi_err_o;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (ex_multi_i && !mem_stall) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                    tmo_nxt   = '0;
                end
            end
            BUSY: begin
                if (ex_multi_done_i) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_MAX) begin
                    err_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!mem_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output priority: memory wait > multi-cycle op > redirect > load-use.
    // Everything is forced low while reset is held.
    always_comb begin
        pc_stall_o      = 1'b0;
        if2id_stall_o   = 1'b0;
        id2ex_stall_o   = 1'b0;
        ex2mem_stall_o  = 1'b0;
        if2id_flush_o   = 1'b0;
        id2ex_flush_o   = 1'b0;
        mem2wb_bubble_o = 1'b0;
        pc_redirect_o   = 1'b0;
        multi_start_o   = 1'b0;
        if (rst) begin
            multi_start_o = start;
            if (mem_stall) begin
                pc_stall_o      = 1'b1;
                if2id_stall_o   = 1'b1;
                id2ex_stall_o   = 1'b1;
                ex2mem_stall_o  = 1'b1;
                mem2wb_bubble_o = 1'b1;
            end else if (multi_stall) begin
                pc_stall_o    = 1'b1;
                if2id_stall_o = 1'b1;
                id2ex_stall_o = 1'b1;
            end else if (ex_redirect_i) begin
                pc_redirect_o = 1'b1;
                if2id_flush_o = 1'b1;
                id2ex_flush_o = 1'b1;
            end else if (lu_hazard) begin
                pc_stall_o    = 1'b1;
                if2id_stall_o = 1'b1;
                id2ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            multi_err_o <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_nxt;
            multi_err_o <= err_nxt;
            if (pc_stall_o) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts every cycle's
// outputs into a queue that a negedge monitor drains against the DUT.
module tb_pipe_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 8;

    typedef struct packed {
        logic       mr;
        logic       rd_en;
        logic [4:0] rd;
        logic       rs1_en;
        logic       rs2_en;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       redir;
        logic       multi;
        logic       done;
        logic       req;
        logic       ready;
    } in_t;

    typedef struct packed {
        logic          pc_stall;
        logic          if2id_stall;
        logic          id2ex_stall;
        logic          ex2mem_stall;
        logic          if2id_flush;
        logic          id2ex_flush;
        logic          mem2wb_bubble;
        logic          pc_redirect;
        logic          multi_start;
        logic          multi_err;
        logic [CW-1:0] stall_cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  cur = '0;
    out_t act;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    out_t exp_q[$];

    // model state, expressed as what the controller "knows" about the multi op
    bit m_running  = 0;
    bit m_finished = 0;
    int m_busy     = 0;
    bit m_err      = 0;
    int m_stalls   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MULTI_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .id2ex_mem_read_i  (cur.mr),
        .id2ex_rd_en_i     (cur.rd_en),
        .id2ex_rd_index_i  (cur.rd),
        .if2id_rs1_en_i    (cur.rs1_en),
        .if2id_rs2_en_i    (cur.rs2_en),
        .if2id_rs1_index_i (cur.rs1),
        .if2id_rs2_index_i (cur.rs2),
        .ex_redirect_i     (cur.redir),
        .ex_multi_i        (cur.multi),
        .ex_multi_done_i   (cur.done),
        .mem_req_i         (cur.req),
        .mem_ready_i       (cur.ready),
        .pc_stall_o        (act.pc_stall),
        .if2id_stall_o     (act.if2id_stall),
        .id2ex_stall_o     (act.id2ex_stall),
        .ex2mem_stall_o    (act.ex2mem_stall),
        .if2id_flush_o     (act.if2id_flush),
        .id2ex_flush_o     (act.id2ex_flush),
        .mem2wb_bubble_o   (act.mem2wb_bubble),
        .pc_redirect_o     (act.pc_redirect),
        .multi_start_o     (act.multi_start),
        .multi_err_o       (act.multi_err),
        .stall_cnt_o       (act.stall_cnt)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL scoreboard cyc=%0d actual=%h required=%h", cyc, act, e);
            end
        end
    end

    task automatic step(input logic r, input in_t i);
        out_t e;
        bit   ms;
        bit   mus;
        bit   lu;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        cur = i;
        e   = '0;
        if (!r) begin
            m_running  = 0;
            m_finished = 0;
            m_busy     = 0;
            m_err      = 0;
            m_stalls   = 0;
        end else begin
            ms  = i.req && !i.ready;
            mus = m_running || (!m_finished && i.multi);
            lu  = i.mr && i.rd_en && (i.rd != 0) &&
                  ((i.rs1_en && i.rs1 == i.rd) || (i.rs2_en && i.rs2 == i.rd));
            e.multi_err = m_err;
            e.stall_cnt = CW'(m_stalls % (1 << CW));
            if (ms) begin
                e.pc_stall = 1; e.if2id_stall = 1; e.id2ex_stall = 1;
                e.ex2mem_stall = 1; e.mem2wb_bubble = 1;
            end else if (mus) begin
                e.pc_stall = 1; e.if2id_stall = 1; e.id2ex_stall = 1;
            end else if (i.redir) begin
                e.pc_redirect = 1; e.if2id_flush = 1; e.id2ex_flush = 1;
            end else if (lu) begin
                e.pc_stall = 1; e.if2id_stall = 1; e.id2ex_flush = 1;
            end
            e.multi_start = !m_running && !m_finished && i.multi && !ms;
            if (e.multi_start) begin
                m_running = 1;
                m_busy    = 0;
            end else if (m_running) begin
                if (i.done) begin
                    m_running  = 0;
                    m_finished = 1;
                end else begin
                    if (m_busy < TMO) m_busy++;
                    if (m_busy >= TMO) m_err = 1;
                end
            end else if (m_finished && !ms) begin
                m_finished = 0;
            end
            if (e.pc_stall) m_stalls++;
        end
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic dchk(input string name, input logic [31:0] a, input logic [31:0] r);
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, a, r);
        end
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t load_use(input logic [4:0] rd, input logic redir);
        in_t v;
        v        = '0;
        v.mr     = 1;
        v.rd_en  = 1;
        v.rd     = rd;
        v.rs2_en = 1;
        v.rs2    = rd;
        v.redir  = redir;
        return v;
    endfunction

    function automatic in_t multi_in(input logic multi, input logic done,
                                     input logic req, input logic ready);
        in_t v;
        v       = '0;
        v.multi = multi;
        v.done  = done;
        v.req   = req;
        v.ready = ready;
        return v;
    endfunction

    initial begin
        in_t r_in;
        bit  hold_multi = 0;

        // reset state
        step(0, idle_in());
        step(0, idle_in());
        settle();
        dchk("reset_cnt", 32'(act.stall_cnt), 0);
        step(1, idle_in());

        // load-use on x5 via rs2
        step(1, load_use(5'd5, 1'b0));
        settle();
        dchk("lu_pc_stall", 32'(act.pc_stall), 1);
        dchk("lu_id2ex_flush", 32'(act.id2ex_flush), 1);
        step(1, idle_in());
        settle();
        dchk("lu_after_stall", 32'(act.pc_stall), 0);
        dchk("lu_after_cnt", 32'(act.stall_cnt), 1);

        // rd = x0 is not a hazard; redirect beats load-use
        step(1, load_use(5'd0, 1'b0));
        settle();
        dchk("lu_x0_stall", 32'(act.pc_stall), 0);
        step(1, load_use(5'd7, 1'b1));
        settle();
        dchk("redir_lu_redirect", 32'(act.pc_redirect), 1);
        dchk("redir_lu_stall", 32'(act.pc_stall), 0);

        // multi op: start cycle 0, done cycle 4, DONE in 5, IDLE in 6
        step(0, idle_in());
        step(1, multi_in(1, 0, 0, 0));
        settle();
        dchk("multi_start_c0", 32'(act.multi_start), 1);
        for (int k = 1; k <= 3; k++) step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 1, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        settle();
        dchk("multi_done_stall", 32'(act.pc_stall), 0);
        dchk("multi_done_start", 32'(act.multi_start), 0);
        step(1, multi_in(0, 0, 0, 0));
        settle();
        dchk("multi_cnt", 32'(act.stall_cnt), 5);

        // memory wait dominates a pending multi start
        step(0, idle_in());
        for (int k = 0; k < 3; k++) begin
            step(1, multi_in(1, 0, 1, 0));
            settle();
            dchk("memwait_no_start", 32'(act.multi_start), 0);
            dchk("memwait_bubble", 32'(act.mem2wb_bubble), 1);
        end
        step(1, multi_in(1, 0, 1, 1));
        settle();
        dchk("memwait_start", 32'(act.multi_start), 1);
        step(1, multi_in(1, 1, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        step(1, idle_in());

        // timeout: no done ever arrives
        step(0, idle_in());
        step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        settle();
        dchk("tmo_early", 32'(act.multi_err), 0);
        step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        settle();
        dchk("tmo_err", 32'(act.multi_err), 1);
        step(1, multi_in(1, 0, 0, 0));
        step(1, multi_in(1, 0, 0, 0));
        settle();
        dchk("tmo_sticky", 32'(act.multi_err), 1);
        dchk("tmo_busy_stall", 32'(act.pc_stall), 1);

        // reset in the middle of BUSY
        step(0, multi_in(1, 0, 0, 0));
        settle();
        dchk("rst_busy_stall", 32'(act.pc_stall), 0);
        dchk("rst_busy_err", 32'(act.multi_err), 0);
        step(1, idle_in());
        settle();
        dchk("rst_rel_cnt", 32'(act.stall_cnt), 0);
        dchk("rst_rel_start", 32'(act.multi_start), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) hold_multi = !hold_multi;
            r_in        = '0;
            r_in.mr     = ($urandom_range(0, 1) == 1);
            r_in.rd_en  = ($urandom_range(0, 3) != 0);
            r_in.rd     = 5'($urandom_range(0, 3));
            r_in.rs1_en = ($urandom_range(0, 1) == 1);
            r_in.rs2_en = ($urandom_range(0, 1) == 1);
            r_in.rs1    = 5'($urandom_range(0, 3));
            r_in.rs2    = 5'($urandom_range(0, 3));
            r_in.redir  = ($urandom_range(0, 7) == 0);
            r_in.multi  = hold_multi;
            r_in.done   = ($urandom_range(0, 4) == 0);
            r_in.req    = ($urandom_range(0, 2) == 0);
            r_in.ready  = ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, r_in);
        end

        step(1, idle_in());
        settle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage core. Every cycle it produces the stall, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from four sources: data-memory wait, multi-cycle EX operations, EX-resolved redirects and load-use hazards. It complements the EX-stage forwarding logic by covering the one case forwarding cannot solve (load-use). It also sequences multi-cycle EX units through a small FSM. It sits beside the stage registers in the core top level.

## Interface
- MULTI_TIMEOUT, 64: maximum number of BUSY cycles before `multi_err_o` sets.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id2ex_mem_read_i  in  1  the instruction in EX is a load.
- id2ex_rd_en_i  in  1  the instruction in EX writes rd.
- id2ex_rd_index_i  in  5  rd of the instruction in EX.
- if2id_rs1_en_i, if2id_rs2_en_i  in  1 each  the instruction in ID reads rs1 / rs2.
- if2id_rs1_index_i, if2id_rs2_index_i  in  5 each  source indices of the instruction in ID.
- ex_redirect_i  in  1  EX resolved a taken branch or jump.
- ex_multi_i  in  1  the instruction in EX needs a multi-cycle unit.
- ex_multi_done_i  in  1  the multi-cycle unit result is valid (1-cycle pulse).
- mem_req_i, mem_ready_i  in  1 each  data-memory request from MEM, and its completion.
- pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o  out  1 each  hold the register.
- if2id_flush_o, id2ex_flush_o  out  1 each  load a bubble into the register.
- mem2wb_bubble_o  out  1  load a bubble into MEM/WB.
- pc_redirect_o  out  1  the PC takes the EX target.
- multi_start_o  out  1  start pulse to the multi-cycle unit.
- multi_err_o  out  1  sticky timeout flag.
- stall_cnt_o  out  CNT_W  number of cycles with `pc_stall_o` high.

## Operation
Derived terms:
- mem_stall = mem_req_i & ~mem_ready_i.
- multi_stall = (state==IDLE & ex_multi_i) | state==BUSY.
- lu_hazard = id2ex_mem_read_i & id2ex_rd_en_i & (id2ex_rd_index_i != 0) & ((if2id_rs1_en_i & rs1==rd) | (if2id_rs2_en_i & rs2==rd)).

Priority, highest first:
- **mem_stall:** assert pc/if2id/id2ex/ex2mem stall and mem2wb_bubble. Suppress every lower source, including multi_start_o and redirect.
- **multi_stall:** assert pc/if2id/id2ex stall. EX/MEM is not stalled; instead ex2mem receives a bubble via `ex2mem_stall_o=0` with the result gated by the stage. Assert pc_stall_o. Suppress redirect and load-use.
- **ex_redirect_i** (valid only when neither source above is active): pc_redirect_o=1, if2id_flush_o=1, id2ex_flush_o=1.
- **lu_hazard:** pc_stall_o=1, if2id_stall_o=1, id2ex_flush_o=1. Lasts exactly 1 cycle because the load advances.

Multi-cycle FSM (states IDLE, BUSY, DONE):
- IDLE → BUSY when ex_multi_i & ~mem_stall. multi_start_o=1 in that cycle only. Clear the timeout counter.
- BUSY → DONE on ex_multi_done_i. Otherwise increment the timeout counter, saturating at MULTI_TIMEOUT. When the counter equals MULTI_TIMEOUT, set multi_err_o (cleared only by reset) and stay in BUSY.
- DONE: ex_multi_i is still high, but no restart and no multi_stall.
  - DONE → IDLE when ~mem_stall.
  - If mem_stall is active, stay in DONE.
  - A redirect in DONE is honoured.
- ex_multi_done_i outside BUSY is ignored.

Counter and reset:
- stall_cnt_o increments in every cycle where pc_stall_o=1. It wraps modulo 2^CNT_W.
- While rst=0: state=IDLE, timeout counter=0, multi_err_o=0, stall_cnt_o=0, and every combinational output is forced to 0.
- Reset asserted mid-BUSY aborts the operation with no multi_start_o re-issue.

## Timing
- All stall, flush, bubble and redirect outputs are combinational from the inputs and the registered state, with zero-cycle latency in the same cycle.
- State, the counters and multi_err_o update on the rising clk edge.
- Multi-op timeline, start in cycle 0 and done in cycle N:
  - stall is asserted in cycles 0..N, so the pipe holds for N+1 cycles.
  - cycle N+1 is DONE, with no stall.
  - EX advances at the end of cycle N+1.
- A done pulse in the same cycle as BUSY entry is impossible: BUSY is only reached after the start edge.
- Simultaneous lu_hazard and redirect: redirect wins and flushes ID, so no stall is applied.
- Simultaneous mem_stall and ex_multi_i in IDLE: no start. Start fires in the first cycle where mem_stall=0.

## Test plan
- **Load-use:** load to x5 in EX, ID reads rs2=x5 → one cycle with pc_stall=1, if2id_stall=1, id2ex_flush=1. Next cycle all stall outputs are 0 and stall_cnt_o=1.
- **Redirect vs load-use:** hazard with rd=x0 → no stall. Hazard plus ex_redirect_i=1 → pc_redirect=1, if2id_flush=1, id2ex_flush=1, pc_stall=0.
- **Multi op:** ex_multi_i held high, done at cycle 4 → multi_start_o only in cycle 0, stall in cycles 0-4, DONE in cycle 5, IDLE in cycle 6, stall_cnt_o=5.
- **Mem wait over multi:** mem_req=1, ready=0 for 3 cycles while ex_multi_i=1 → all four stalls plus mem2wb_bubble, no start. multi_start_o fires in the cycle ready returns.
- **Timeout:** MULTI_TIMEOUT=4, done never arrives → multi_err_o=1 after 4 BUSY cycles, stays 1, FSM stays in BUSY.
- **Reset mid-BUSY:** rst=0 → all outputs 0 immediately. After release: IDLE, counters 0, multi_err_o=0.
